// File: rtl/mmu_tlb.sv
// MIPS32-style MMU: kseg0/kseg1 fixed mapping plus a fully-associative software-managed TLB with CP0 ops.
// Optional MMU_MISS_CNT_EN adds saturating refill counters for the inst and data ports.
module mmu_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int ASID_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [ASID_W-1:0]     asid,
  input  logic [2:0]            k0_cca,
  input  logic [31:0]           inst_vaddr,
  output logic [31:0]           inst_paddr,
  output logic                  inst_no_cache,
  output logic                  inst_refill,
  output logic                  inst_invalid,
  input  logic [31:0]           data_vaddr,
  input  logic                  data_sram_en,
  input  logic [3:0]            data_sram_wen,
  output logic [31:0]           data_paddr,
  output logic                  data_no_cache,
  output logic                  data_refill,
  output logic                  data_invalid,
  output logic                  data_modified,
  input  logic [2:0]            tlb_op,
  input  logic [IDX_W-1:0]      cp0_index,
  input  logic [19+ASID_W-1:0]  cp0_entryhi,
  input  logic [25:0]           cp0_entrylo0,
  input  logic [25:0]           cp0_entrylo1,
  output logic                  tlbp_valid,
  output logic                  tlbp_found,
  output logic [IDX_W-1:0]      tlbp_index,
  output logic                  tlbr_valid,
  output logic [19+ASID_W-1:0]  tlbr_entryhi,
  output logic [25:0]           tlbr_entrylo0,
  output logic [25:0]           tlbr_entrylo1,
  output logic [IDX_W-1:0]      random_idx
`ifdef MMU_MISS_CNT_EN
  ,
  output logic [31:0]           inst_refill_cnt,
  output logic [31:0]           data_refill_cnt
`endif
);

  localparam int HI_W = 19 + ASID_W;
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  localparam logic [2:0] OP_TLBWI = 3'd1;
  localparam logic [2:0] OP_TLBWR = 3'd2;
  localparam logic [2:0] OP_TLBP  = 3'd3;
  localparam logic [2:0] OP_TLBR  = 3'd4;

  logic [TLB_ENTRIES-1:0] present_q;
  logic [18:0]            vpn2_q [TLB_ENTRIES];
  logic [ASID_W-1:0]      asid_q [TLB_ENTRIES];
  logic [19:0]            pfn0_q [TLB_ENTRIES];
  logic [19:0]            pfn1_q [TLB_ENTRIES];
  logic [2:0]             c0_q   [TLB_ENTRIES];
  logic [2:0]             c1_q   [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] g_q, d0_q, d1_q, v0_q, v1_q;

  logic [IDX_W-1:0] random_q, random_d;

  // Lowest matching index wins; returns 0 when nothing matches.
  function automatic logic [IDX_W-1:0] first_idx(input logic [TLB_ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
      if (m[k]) r = k[IDX_W-1:0];
    end
    return r;
  endfunction

  logic [TLB_ENTRIES-1:0] inst_match, data_match, p_match;
  always_comb begin
    inst_match = '0;
    data_match = '0;
    p_match    = '0;
    for (int k = 0; k < TLB_ENTRIES; k++) begin
      inst_match[k] = present_q[k] && (vpn2_q[k] == inst_vaddr[31:13]) &&
                      (g_q[k] || (asid_q[k] == asid));
      data_match[k] = present_q[k] && (vpn2_q[k] == data_vaddr[31:13]) &&
                      (g_q[k] || (asid_q[k] == asid));
      p_match[k]    = present_q[k] && (vpn2_q[k] == cp0_entryhi[HI_W-1:ASID_W]) &&
                      (g_q[k] || (asid_q[k] == cp0_entryhi[ASID_W-1:0]));
    end
  end

  logic [IDX_W-1:0] inst_idx, data_idx;
  logic [19:0]      inst_pfn, data_pfn;
  logic [2:0]       inst_c, data_c;
  logic             inst_v, data_v, data_dirty;
  logic [31:0]      inst_paddr_d, data_paddr_d;
  logic             inst_nc_d, inst_refill_d, inst_invalid_d;
  logic             data_nc_d, data_refill_d, data_invalid_d, data_modified_d;

  always_comb begin
    inst_idx = first_idx(inst_match);
    inst_pfn = '0;
    inst_c   = 3'd0;
    inst_v   = 1'b0;
    if (|inst_match) begin
      inst_pfn = inst_vaddr[12] ? pfn1_q[inst_idx] : pfn0_q[inst_idx];
      inst_c   = inst_vaddr[12] ? c1_q[inst_idx]   : c0_q[inst_idx];
      inst_v   = inst_vaddr[12] ? v1_q[inst_idx]   : v0_q[inst_idx];
    end
    if (inst_vaddr[31:30] == 2'b10) begin
      inst_paddr_d   = {3'b000, inst_vaddr[28:0]};
      inst_nc_d      = inst_vaddr[29] || (k0_cca != 3'd3);
      inst_refill_d  = 1'b0;
      inst_invalid_d = 1'b0;
    end else begin
      inst_paddr_d   = {inst_pfn, inst_vaddr[11:0]};
      inst_nc_d      = (inst_c != 3'd3);
      inst_refill_d  = !(|inst_match);
      inst_invalid_d = (|inst_match) && !inst_v;
    end
  end

  always_comb begin
    data_idx   = first_idx(data_match);
    data_pfn   = '0;
    data_c     = 3'd0;
    data_v     = 1'b0;
    data_dirty = 1'b0;
    if (|data_match) begin
      data_pfn   = data_vaddr[12] ? pfn1_q[data_idx] : pfn0_q[data_idx];
      data_c     = data_vaddr[12] ? c1_q[data_idx]   : c0_q[data_idx];
      data_v     = data_vaddr[12] ? v1_q[data_idx]   : v0_q[data_idx];
      data_dirty = data_vaddr[12] ? d1_q[data_idx]   : d0_q[data_idx];
    end
    if (data_vaddr[31:30] == 2'b10) begin
      data_paddr_d    = {3'b000, data_vaddr[28:0]};
      data_nc_d       = data_vaddr[29] || (k0_cca != 3'd3);
      data_refill_d   = 1'b0;
      data_invalid_d  = 1'b0;
      data_modified_d = 1'b0;
    end else begin
      data_paddr_d    = {data_pfn, data_vaddr[11:0]};
      data_nc_d       = (data_c != 3'd3);
      data_refill_d   = data_sram_en && !(|data_match);
      data_invalid_d  = data_sram_en && (|data_match) && !data_v;
      data_modified_d = data_sram_en && (|data_sram_wen) && (|data_match) && data_v && !data_dirty;
    end
  end

  logic [31:0] inst_paddr_q, data_paddr_q;
  logic        inst_nc_q, inst_refill_q, inst_invalid_q;
  logic        data_nc_q, data_refill_q, data_invalid_q, data_modified_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_paddr_q    <= '0;
      inst_nc_q       <= 1'b0;
      inst_refill_q   <= 1'b0;
      inst_invalid_q  <= 1'b0;
      data_paddr_q    <= '0;
      data_nc_q       <= 1'b0;
      data_refill_q   <= 1'b0;
      data_invalid_q  <= 1'b0;
      data_modified_q <= 1'b0;
    end else if (!stall) begin
      inst_paddr_q    <= inst_paddr_d;
      inst_nc_q       <= inst_nc_d;
      inst_refill_q   <= inst_refill_d;
      inst_invalid_q  <= inst_invalid_d;
      data_paddr_q    <= data_paddr_d;
      data_nc_q       <= data_nc_d;
      data_refill_q   <= data_refill_d;
      data_invalid_q  <= data_invalid_d;
      data_modified_q <= data_modified_d;
    end
  end

  // Writes land at the edge, so same-cycle lookups above still see the old entry.
  logic             tlb_we;
  logic [IDX_W-1:0] tlb_widx;
  assign tlb_we   = !rst && ((tlb_op == OP_TLBWI) || (tlb_op == OP_TLBWR));
  assign tlb_widx = (tlb_op == OP_TLBWR) ? random_q : cp0_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      present_q <= '0;
    end else if (tlb_we) begin
      present_q[tlb_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tlb_we) begin
      vpn2_q[tlb_widx] <= cp0_entryhi[HI_W-1:ASID_W];
      asid_q[tlb_widx] <= cp0_entryhi[ASID_W-1:0];
      g_q[tlb_widx]    <= cp0_entrylo0[0] & cp0_entrylo1[0];
      pfn0_q[tlb_widx] <= cp0_entrylo0[25:6];
      c0_q[tlb_widx]   <= cp0_entrylo0[5:3];
      d0_q[tlb_widx]   <= cp0_entrylo0[2];
      v0_q[tlb_widx]   <= cp0_entrylo0[1];
      pfn1_q[tlb_widx] <= cp0_entrylo1[25:6];
      c1_q[tlb_widx]   <= cp0_entrylo1[5:3];
      d1_q[tlb_widx]   <= cp0_entrylo1[2];
      v1_q[tlb_widx]   <= cp0_entrylo1[1];
    end
  end

  logic                tlbp_valid_q, tlbp_found_q, tlbr_valid_q;
  logic [IDX_W-1:0]    tlbp_index_q;
  logic [HI_W-1:0]     tlbr_hi_q;
  logic [25:0]         tlbr_lo0_q, tlbr_lo1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tlbp_valid_q <= 1'b0;
      tlbp_found_q <= 1'b0;
      tlbp_index_q <= '0;
      tlbr_valid_q <= 1'b0;
      tlbr_hi_q    <= '0;
      tlbr_lo0_q   <= '0;
      tlbr_lo1_q   <= '0;
    end else begin
      tlbp_valid_q <= (tlb_op == OP_TLBP);
      tlbr_valid_q <= (tlb_op == OP_TLBR);
      if (tlb_op == OP_TLBP) begin
        tlbp_found_q <= |p_match;
        tlbp_index_q <= first_idx(p_match);
      end
      if (tlb_op == OP_TLBR) begin
        tlbr_hi_q  <= {vpn2_q[cp0_index], asid_q[cp0_index]};
        tlbr_lo0_q <= {pfn0_q[cp0_index], c0_q[cp0_index], d0_q[cp0_index],
                       v0_q[cp0_index], g_q[cp0_index]};
        tlbr_lo1_q <= {pfn1_q[cp0_index], c1_q[cp0_index], d1_q[cp0_index],
                       v1_q[cp0_index], g_q[cp0_index]};
      end
    end
  end

  always_comb begin
    random_d = (random_q == '0) ? RAND_TOP : random_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) random_q <= RAND_TOP;
    else     random_q <= random_d;
  end

`ifdef MMU_MISS_CNT_EN
  logic [31:0] inst_cnt_q, data_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
    end else if (!stall) begin
      if (inst_refill_q && (inst_cnt_q != '1)) inst_cnt_q <= inst_cnt_q + 32'd1;
      if (data_refill_q && (data_cnt_q != '1)) data_cnt_q <= data_cnt_q + 32'd1;
    end
  end
  assign inst_refill_cnt = inst_cnt_q;
  assign data_refill_cnt = data_cnt_q;
`endif

  assign inst_paddr    = inst_paddr_q;
  assign inst_no_cache = inst_nc_q;
  assign inst_refill   = inst_refill_q;
  assign inst_invalid  = inst_invalid_q;
  assign data_paddr    = data_paddr_q;
  assign data_no_cache = data_nc_q;
  assign data_refill   = data_refill_q;
  assign data_invalid  = data_invalid_q;
  assign data_modified = data_modified_q;
  assign tlbp_valid    = tlbp_valid_q;
  assign tlbp_found    = tlbp_found_q;
  assign tlbp_index    = tlbp_index_q;
  assign tlbr_valid    = tlbr_valid_q;
  assign tlbr_entryhi  = tlbr_hi_q;
  assign tlbr_entrylo0 = tlbr_lo0_q;
  assign tlbr_entrylo1 = tlbr_lo1_q;
  assign random_idx    = random_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: segments, TLB write/lookup/faults, TLBP/TLBR, Random and stall.
module tb_mmu_tlb;
  localparam int N = 16;
  localparam int IW = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic [AW-1:0] asid;
  logic [2:0]    k0_cca;
  logic [31:0]   inst_vaddr, inst_paddr;
  logic          inst_no_cache, inst_refill, inst_invalid;
  logic [31:0]   data_vaddr, data_paddr;
  logic          data_sram_en;
  logic [3:0]    data_sram_wen;
  logic          data_no_cache, data_refill, data_invalid, data_modified;
  logic [2:0]    tlb_op;
  logic [IW-1:0] cp0_index, tlbp_index, random_idx;
  logic [18+AW:0] cp0_entryhi, tlbr_entryhi;
  logic [25:0]   cp0_entrylo0, cp0_entrylo1, tlbr_entrylo0, tlbr_entrylo1;
  logic          tlbp_valid, tlbp_found, tlbr_valid;
`ifdef MMU_MISS_CNT_EN
  logic [31:0]   inst_refill_cnt, data_refill_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_rand = N - 1;
  logic [IW-1:0] wr_idx;

  always #5 clk = ~clk;

  mmu_tlb #(.TLB_ENTRIES(N), .IDX_W(IW), .ASID_W(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .asid(asid), .k0_cca(k0_cca),
    .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr), .inst_no_cache(inst_no_cache),
    .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .data_vaddr(data_vaddr), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_paddr(data_paddr), .data_no_cache(data_no_cache), .data_refill(data_refill),
    .data_invalid(data_invalid), .data_modified(data_modified),
    .tlb_op(tlb_op), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .tlbp_valid(tlbp_valid), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
    .tlbr_valid(tlbr_valid), .tlbr_entryhi(tlbr_entryhi),
    .tlbr_entrylo0(tlbr_entrylo0), .tlbr_entrylo1(tlbr_entrylo1),
    .random_idx(random_idx)
`ifdef MMU_MISS_CNT_EN
    , .inst_refill_cnt(inst_refill_cnt), .data_refill_cnt(data_refill_cnt)
`endif
  );

  // Advance one edge, track the expected Random value, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) exp_rand = N - 1;
    else     exp_rand = (exp_rand == 0) ? N - 1 : exp_rand - 1;
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; asid = '0; k0_cca = 3'd3;
    inst_vaddr = '0; data_vaddr = '0; data_sram_en = 1'b0; data_sram_wen = '0;
    tlb_op = '0; cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    tick(); tick();
    check("rst_inst_paddr", inst_paddr, 0);
    check("rst_inst_refill", inst_refill, 0);
    check("rst_data_refill", data_refill, 0);
    check("rst_tlbp_valid", tlbp_valid, 0);
    check("rst_tlbr_entryhi", tlbr_entryhi, 0);
    rst = 1'b0;
    check("rand_start", random_idx, 15);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("rand_seq", random_idx, (i == 16) ? 15 : 15 - i);
    end

    // Unmapped segments
    inst_vaddr = 32'hBFC00000; data_vaddr = 32'h80001000; data_sram_en = 1'b1; k0_cca = 3'd3;
    tick();
    check("kseg1_paddr", inst_paddr, 32'h1FC00000);
    check("kseg1_nc", inst_no_cache, 1);
    check("kseg0_paddr", data_paddr, 32'h00001000);
    check("kseg0_nc_k3", data_no_cache, 0);
    check("kseg0_refill", data_refill, 0);
    k0_cca = 3'd2;
    tick();
    check("kseg0_nc_k2", data_no_cache, 1);

    // Miss after reset, TLBP miss
    inst_vaddr = 32'h00400000; data_vaddr = 32'h00400000;
    tlb_op = 3'd3; cp0_entryhi = {19'h00200, 8'h12};
    tick();
    check("miss_data_refill", data_refill, 1);
    check("miss_inst_refill", inst_refill, 1);
    check("tlbp_miss_valid", tlbp_valid, 1);
    check("tlbp_miss_found", tlbp_found, 0);
    check("tlbp_miss_index", tlbp_index, 0);
    tlb_op = 3'd0;
    tick();
    check("tlbp_pulse_end", tlbp_valid, 0);

    // TLBWI index 5; same-cycle lookup still misses
    asid = 8'h12; inst_vaddr = 32'h00400ABC; data_vaddr = 32'h00400ABC;
    tlb_op = 3'd1; cp0_index = 4'd5; cp0_entryhi = {19'h00200, 8'h12};
    cp0_entrylo0 = {20'h01234, 3'd3, 1'b1, 1'b1, 1'b0};
    cp0_entrylo1 = {20'h00000, 3'd3, 1'b0, 1'b0, 1'b0};
    tick();
    check("wr_same_cycle_refill", data_refill, 1);
    tlb_op = 3'd0;
    tick();
    check("hit_data_paddr", data_paddr, 32'h01234ABC);
    check("hit_data_nc", data_no_cache, 0);
    check("hit_data_refill", data_refill, 0);
    check("hit_data_invalid", data_invalid, 0);
    check("hit_inst_paddr", inst_paddr, 32'h01234ABC);
    inst_vaddr = 32'h00401000; data_vaddr = 32'h00401000;
    tick();
    check("odd_invalid", data_invalid, 1);
    check("odd_refill", data_refill, 0);
    check("odd_paddr", data_paddr, 32'h00000000);
    check("odd_inst_invalid", inst_invalid, 1);
    asid = 8'h13; data_vaddr = 32'h00400ABC;
    tick();
    check("asid_refill", data_refill, 1);

    // Dirty check: rewrite entry 5 with D=0
    asid = 8'h12; tlb_op = 3'd1;
    cp0_entrylo0 = {20'h01234, 3'd3, 1'b0, 1'b1, 1'b0};
    tick();
    tlb_op = 3'd0; data_sram_wen = 4'hF;
    tick();
    check("store_modified", data_modified, 1);
    check("store_paddr", data_paddr, 32'h01234ABC);
    data_sram_en = 1'b0;
    tick();
    check("noen_modified", data_modified, 0);
    data_sram_en = 1'b1; data_sram_wen = 4'h0;
    tick();
    check("load_modified", data_modified, 0);
    check("load_refill", data_refill, 0);
    check("load_invalid", data_invalid, 0);

    // Global entries 2 and 7 with the same VPN2
    tlb_op = 3'd1; cp0_index = 4'd2; cp0_entryhi = {19'h00300, 8'h55};
    cp0_entrylo0 = {20'hAAAAA, 3'd2, 1'b1, 1'b1, 1'b1};
    cp0_entrylo1 = {20'hBBBBB, 3'd3, 1'b1, 1'b1, 1'b1};
    tick();
    cp0_index = 4'd7; cp0_entryhi = {19'h00300, 8'h66};
    cp0_entrylo0 = {20'h77777, 3'd3, 1'b1, 1'b1, 1'b1};
    cp0_entrylo1 = {20'h88888, 3'd3, 1'b1, 1'b1, 1'b1};
    tick();
    tlb_op = 3'd3; cp0_entryhi = {19'h00300, 8'h99}; data_vaddr = 32'h00600123;
    tick();
    check("tlbp_g_valid", tlbp_valid, 1);
    check("tlbp_g_found", tlbp_found, 1);
    check("tlbp_g_index", tlbp_index, 2);
    tlb_op = 3'd0;
    tick();
    check("prio_paddr", data_paddr, 32'hAAAAA123);
    check("prio_nc", data_no_cache, 1);
    tlb_op = 3'd4; cp0_index = 4'd7;
    tick();
    check("tlbr_valid", tlbr_valid, 1);
    check("tlbr7_hi", tlbr_entryhi, {19'h00300, 8'h66});
    check("tlbr7_lo0", tlbr_entrylo0, {20'h77777, 3'd3, 1'b1, 1'b1, 1'b1});
    check("tlbr7_lo1_g", tlbr_entrylo1[0], 1);

    // TLBWR at the current Random value, G = lo0.G & lo1.G = 0
    check("rand_model", random_idx, exp_rand);
    wr_idx = exp_rand[IW-1:0];
    tlb_op = 3'd2; cp0_entryhi = {19'h004AB, 8'h21};
    cp0_entrylo0 = {20'h12345, 3'd3, 1'b1, 1'b1, 1'b1};
    cp0_entrylo1 = {20'h54321, 3'd0, 1'b0, 1'b1, 1'b0};
    tick();
    check("tlbr_pulse_end", tlbr_valid, 0);
    tlb_op = 3'd4; cp0_index = wr_idx; asid = 8'h21; data_vaddr = 32'h00957456;
    tick();
    check("tlbwr_hi", tlbr_entryhi, {19'h004AB, 8'h21});
    check("tlbwr_lo0", tlbr_entrylo0, {20'h12345, 3'd3, 1'b1, 1'b1, 1'b0});
    check("tlbwr_lo1", tlbr_entrylo1, {20'h54321, 3'd0, 1'b0, 1'b1, 1'b0});
    check("tlbwr_paddr", data_paddr, 32'h54321456);
    check("tlbwr_nc", data_no_cache, 1);

    // Stall holds translation outputs but not TLBP pulses or Random
    tlb_op = 3'd0; k0_cca = 3'd3; data_vaddr = 32'h80002000;
    tick();
    check("pre_stall_paddr", data_paddr, 32'h00002000);
    stall = 1'b1; data_vaddr = 32'h80003000; tlb_op = 3'd3;
    tick();
    check("stall_hold_paddr", data_paddr, 32'h00002000);
    check("stall_tlbp_valid", tlbp_valid, 1);
    check("stall_rand", random_idx, exp_rand);
    stall = 1'b0; tlb_op = 3'd0;
    tick();
    check("post_stall_paddr", data_paddr, 32'h00003000);

    // Reset beats a same-cycle TLBWI
    rst = 1'b1; tlb_op = 3'd1; cp0_index = 4'd3; cp0_entryhi = {19'h00500, 8'h00};
    cp0_entrylo0 = {20'h00001, 3'd3, 1'b1, 1'b1, 1'b1};
    cp0_entrylo1 = {20'h00002, 3'd3, 1'b1, 1'b1, 1'b1};
    tick();
    rst = 1'b0; tlb_op = 3'd3; asid = 8'h12; data_vaddr = 32'h00400ABC;
    check("rst_again_rand", random_idx, 15);
    check("rst_again_paddr", data_paddr, 0);
    tick();
    check("rst_drop_found", tlbp_found, 0);
    check("rst_drop_valid", tlbp_valid, 1);
    check("rst_clears_present", data_refill, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
Parametrised successor to the fixed-segment address translator. Adds a fully-associative, software-managed MIPS32-style TLB with a configurable entry count, plus ASID matching, even/odd page pairs and a Config.K0-driven kseg0 cache attribute. It translates one instruction and one data address per cycle through a registered pipeline stage, and executes CP0 TLBWI/TLBWR/TLBP/TLBR operations. It sits between the core's fetch/memory stages and the icache/dcache/uncached bridges.

Parameters:
TLB_ENTRIES, 16, number of TLB entries; power of two, 2..64
IDX_W, $clog2(TLB_ENTRIES), width of the index and random fields
ASID_W, 8, ASID width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hold the translation output registers
asid  in  ASID_W  current EntryHi.ASID
k0_cca  in  3  Config.K0
inst_vaddr  in  32  fetch virtual address
inst_paddr  out  32  registered physical address
inst_no_cache  out  1  registered uncached flag
inst_refill  out  1  registered TLB miss (no matching entry)
inst_invalid  out  1  registered match with V=0
data_vaddr  in  32  load/store virtual address
data_sram_en  in  1  data access valid
data_sram_wen  in  4  byte write enables; a store is data_sram_en & |data_sram_wen
data_paddr  out  32  registered physical address
data_no_cache  out  1  registered uncached flag
data_refill  out  1  registered TLB miss
data_invalid  out  1  registered match with V=0
data_modified  out  1  registered store to a valid page with D=0
tlb_op  in  3  0 none, 1 TLBWI, 2 TLBWR, 3 TLBP, 4 TLBR; others are ignored
cp0_index  in  IDX_W  Index register
cp0_entryhi  in  19+ASID_W  {VPN2[18:0], ASID}
cp0_entrylo0  in  26  {PFN[19:0], C[2:0], D, V, G}
cp0_entrylo1  in  26  same layout as entrylo0, odd page
tlbp_valid  out  1  pulses one cycle after a TLBP
tlbp_found  out  1  TLBP hit
tlbp_index  out  IDX_W  index of the TLBP hit
tlbr_valid  out  1  pulses one cycle after a TLBR
tlbr_entryhi  out  19+ASID_W  entry read by TLBR
tlbr_entrylo0  out  26  entry read by TLBR
tlbr_entrylo1  out  26  entry read by TLBR
random_idx  out  IDX_W  current Random value

Behaviour:
- Segments, per address:
  - kseg0 (vaddr[31:29]=100): paddr = {3'b0, va[28:0]}; no_cache = (k0_cca != 3).
  - kseg1 (101): paddr = {3'b0, va[28:0]}; no_cache = 1.
  - kuseg, kseg2 and kseg3: mapped through the TLB.
- Entry storage: VPN2, ASID, G, PFN0/C0/D0/V0, PFN1/C1/D1/V1, plus an internal present bit.
- Match rule: present and VPN2 == va[31:13], and (G or entry ASID == asid).
- Page select: va[12] selects the odd half. paddr = {PFN, va[11:0]}; no_cache = (C != 3).
- Multiple matches: the lowest index wins. This applies to TLBP too.
- Mapped miss: refill=1. Match with V=0: invalid=1. data_modified=1 only for a store to a valid page with D=0.
- Fault flags are qualified: the data flags require data_sram_en=1; the inst flags are always evaluated. On any fault, paddr is still driven with {PFN or 0, offset}, and the consumer discards it.
- Latency: all translation outputs are registered, one cycle after the inputs. While stall=1 the output registers hold their values.
- TLBWI writes entry cp0_index; TLBWR writes entry random_idx. The write happens at the clock edge, sets present=1, and stores G = lo0.G & lo1.G.
- A lookup in the same cycle as a write sees the old contents. The new contents are visible from the next cycle.
- TLBP compares cp0_entryhi against all entries and registers tlbp_found/tlbp_index. tlbp_index is 0 when there is no hit.
- TLBR registers entry cp0_index. G is reported in both entrylo G bits.
- tlbp_valid and tlbr_valid are single-cycle pulses and are not affected by stall.
- Random: a down-counter decrements every cycle and wraps from 0 to TLB_ENTRIES-1. It is unaffected by stall.
- Reset:
  - All present bits clear, so every mapped access refills.
  - All outputs 0.
  - random_idx = TLB_ENTRIES-1.
- rst takes priority over any tlb_op in the same cycle; the write is dropped.

Optional Feature:
MMU_MISS_CNT_EN: adds 32-bit outputs inst_refill_cnt and data_refill_cnt. Each increments on every cycle its registered refill flag is 1 and stall=0, saturates at all-ones, and clears on rst. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Unmapped segments: inst_vaddr=0xBFC00000 -> next cycle inst_paddr=0x1FC00000, inst_no_cache=1. data_vaddr=0x80001000 with k0_cca=3 -> data_paddr=0x00001000, data_no_cache=0; with k0_cca=2 -> data_no_cache=1.
- Miss after reset: data_vaddr=0x00400000, data_sram_en=1 -> data_refill=1. TLBP with entryhi VPN2=0x200 -> tlbp_valid=1, tlbp_found=0.
- Write and translate: TLBWI index 5, VPN2=0x00200, ASID=0x12, lo0 PFN=0x01234 C=3 V=1 D=1, lo1 V=0. Then va=0x00400ABC with asid=0x12 -> paddr=0x01234ABC, no_cache=0. va=0x00401000 -> invalid=1. asid=0x13 -> refill=1.
- Dirty check: same entry with D=0, store wen=4'b1111 -> data_modified=1. Load (wen=0) -> no fault.
- Global and priority: entries 2 and 7 both written with VPN2=0x300 and G=1. TLBP -> found=1, index=2. TLBR index 7 -> tlbr_entrylo0.G=1 and tlbr_entrylo1.G=1.
- Random and stall: random_idx counts 15,14,…,0,15 from reset. TLBWR lands at the sampled random_idx, checked via TLBR. With stall=1, a changed vaddr does not update paddr.
